// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: opcodes, default address width and PC-select FSM states.
package y86_pkg;

  localparam int ADDR_W_DEF = 64;

  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    RET_WAIT = 1'b1
  } pc_state_t;

  // jXX (predicted taken) and call both continue at their valC.
  function automatic logic takes_valc(input logic [3:0] icode);
    return (icode == I_JXX) || (icode == I_CALL);
  endfunction

endpackage

// File: rtl/pc_select_unit_if.sv
// Fetch/M/W bundle feeding the PC-select unit, plus the PC it hands back to fetch.
interface pc_select_unit_if #(
  parameter int ADDR_W = y86_pkg::ADDR_W_DEF
);

  logic              f_valid;
  logic              f_stall;
  logic [3:0]        f_icode;
  logic [ADDR_W-1:0] f_valC;
  logic [ADDR_W-1:0] f_valP;
  logic [3:0]        m_icode;
  logic              m_cnd;
  logic [ADDR_W-1:0] m_valA;
  logic [3:0]        w_icode;
  logic [ADDR_W-1:0] w_valM;
  logic [ADDR_W-1:0] f_pc;
  logic [ADDR_W-1:0] pred_pc;
  logic              ret_wait;
  logic              redirect;

  modport master (
    output f_valid, f_stall, f_icode, f_valC, f_valP,
    output m_icode, m_cnd, m_valA, w_icode, w_valM,
    input  f_pc, pred_pc, ret_wait, redirect
  );

  modport slave (
    input  f_valid, f_stall, f_icode, f_valC, f_valP,
    input  m_icode, m_cnd, m_valA, w_icode, w_valM,
    output f_pc, pred_pc, ret_wait, redirect
  );

endinterface

// File: rtl/pc_select_unit_ras_stack.sv
// Circular return-address LIFO; a push into a full stack overwrites the oldest entry.
// Only built when RET_STACK_EN is defined.
`ifdef RET_STACK_EN
module ras_stack #(
  parameter int ADDR_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  sp_r;
  logic [CNT_W-1:0]  cnt_r;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(DEPTH - 1) : p - 1'b1;
  endfunction

  assign top   = mem_r[ptr_dec(sp_r)];
  assign empty = (cnt_r == '0);

  // sp_r is the next free slot; the count saturates so wrap-around silently drops the oldest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_r  <= '0;
      cnt_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push) begin
      mem_r[sp_r] <= push_data;
      sp_r        <= ptr_inc(sp_r);
      if (cnt_r != CNT_W'(DEPTH)) begin
        cnt_r <= cnt_r + 1'b1;
      end
    end else if (pop && !empty) begin
      sp_r  <= ptr_dec(sp_r);
      cnt_r <= cnt_r - 1'b1;
    end
  end

endmodule
`endif

// File: rtl/pc_select_unit.sv
// Fetch PC selection with registered prediction; M mispredicts and W rets correct it late.
// Optional RET_STACK_EN adds a return-address stack with a W-stage check queue.
module pc_select_unit
  import y86_pkg::*;
#(
  parameter int              ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  pc_select_unit_if.slave   bus
);

  logic              mispredict_s;
  logic              w_ret_s;
  logic              w_redirect_s;
  logic              redirect_s;
  logic              accept_s;
  logic              fetch_ret_s;
  logic [ADDR_W-1:0] npc_s;
  logic [ADDR_W-1:0] f_pc_s;
  logic [ADDR_W-1:0] pred_pc_r;
  logic [ADDR_W-1:0] pred_pc_nxt_s;
  pc_state_t         state_r;
  pc_state_t         state_nxt_s;

  assign mispredict_s = (bus.m_icode == I_JXX) && !bus.m_cnd;
  assign w_ret_s      = (bus.w_icode == I_RET);
  assign redirect_s   = !rst && (mispredict_s || w_redirect_s);
  assign npc_s        = takes_valc(bus.f_icode) ? bus.f_valC : bus.f_valP;

  // While waiting on a ret only a correction may consume the fetch slot.
  assign accept_s    = (!bus.f_stall || redirect_s) && ((state_r == RUN) || redirect_s);
  assign fetch_ret_s = accept_s && bus.f_valid && (bus.f_icode == I_RET);

`ifdef RET_STACK_EN
  localparam int QPTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int QCNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] ras_top_s;
  logic              ras_empty_s;
  logic              ras_push_s;
  logic              ras_pop_s;
  logic [ADDR_W-1:0] q_mem_r [RAS_DEPTH];
  logic [QPTR_W-1:0] q_rd_r;
  logic [QPTR_W-1:0] q_wr_r;
  logic [QCNT_W-1:0] q_cnt_r;
  logic              q_empty_s;
  logic              q_full_s;
  logic              q_deq_s;
  logic              q_enq_ok_s;
  logic              q_clear_s;

  function automatic logic [QPTR_W-1:0] q_next(input logic [QPTR_W-1:0] p);
    return (p == QPTR_W'(RAS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ras_push_s = accept_s && bus.f_valid && (bus.f_icode == I_CALL);
  assign ras_pop_s  = fetch_ret_s && !ras_empty_s;

  ras_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .push_data (bus.f_valP),
    .top       (ras_top_s),
    .empty     (ras_empty_s)
  );

  // An empty queue means the ret in W is the one fetch stalled on, so it must redirect.
  assign q_empty_s    = (q_cnt_r == '0);
  assign q_full_s     = (q_cnt_r == QCNT_W'(RAS_DEPTH));
  assign w_redirect_s = w_ret_s && (q_empty_s || (q_mem_r[q_rd_r] != bus.w_valM));
  assign q_deq_s      = w_ret_s && !q_empty_s;
  assign q_enq_ok_s   = ras_pop_s && (!q_full_s || q_deq_s);
  assign q_clear_s    = mispredict_s || w_redirect_s;

  // Check queue of predicted return addresses awaiting confirmation in W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_rd_r  <= '0;
      q_wr_r  <= '0;
      q_cnt_r <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        q_mem_r[i] <= '0;
      end
    end else if (q_clear_s) begin
      q_rd_r <= '0;
      if (q_enq_ok_s) begin
        q_mem_r[0] <= ras_top_s;
        q_wr_r     <= q_next('0);
        q_cnt_r    <= QCNT_W'(1);
      end else begin
        q_wr_r  <= '0;
        q_cnt_r <= '0;
      end
    end else begin
      if (q_enq_ok_s) begin
        q_mem_r[q_wr_r] <= ras_top_s;
        q_wr_r          <= q_next(q_wr_r);
      end
      if (q_deq_s) begin
        q_rd_r <= q_next(q_rd_r);
      end
      case ({q_enq_ok_s, q_deq_s})
        2'b10:   q_cnt_r <= q_cnt_r + 1'b1;
        2'b01:   q_cnt_r <= q_cnt_r - 1'b1;
        default: q_cnt_r <= q_cnt_r;
      endcase
    end
  end
`else
  assign w_redirect_s = w_ret_s;
`endif

  // Correction priority: M mispredict beats W ret beats the registered prediction.
  always_comb begin
    f_pc_s = pred_pc_r;
    if (rst) begin
      f_pc_s = RESET_PC;
    end else if (mispredict_s) begin
      f_pc_s = bus.m_valA;
    end else if (w_redirect_s) begin
      f_pc_s = bus.w_valM;
    end else begin
      f_pc_s = pred_pc_r;
    end
  end

  // Next-state and next-prediction logic.
  always_comb begin
    state_nxt_s   = state_r;
    pred_pc_nxt_s = pred_pc_r;
    if (!accept_s) begin
      state_nxt_s   = state_r;
      pred_pc_nxt_s = pred_pc_r;
    end else if (fetch_ret_s) begin
`ifdef RET_STACK_EN
      if (!ras_empty_s) begin
        state_nxt_s   = RUN;
        pred_pc_nxt_s = ras_top_s;
      end else begin
        state_nxt_s   = RET_WAIT;
        pred_pc_nxt_s = pred_pc_r;
      end
`else
      state_nxt_s   = RET_WAIT;
      pred_pc_nxt_s = pred_pc_r;
`endif
    end else begin
      state_nxt_s   = RUN;
      pred_pc_nxt_s = bus.f_valid ? npc_s : f_pc_s;
    end
  end

  // Prediction register and FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= RUN;
      pred_pc_r <= RESET_PC;
    end else begin
      state_r   <= state_nxt_s;
      pred_pc_r <= pred_pc_nxt_s;
    end
  end

  assign bus.f_pc     = f_pc_s;
  assign bus.pred_pc  = pred_pc_r;
  assign bus.ret_wait = (state_r == RET_WAIT);
  assign bus.redirect = redirect_s;

endmodule
